// File: rtl/jtag_ir_dr_regs_if.sv
// TAP-side bundle for jtag_ir_dr_regs: the TAP controller's strobes and
// serial data in, plus the serial return path to the pin.
// master = TAP controller / pin side, slave = IR/DR register stage.
interface jtag_ir_dr_regs_if;
  logic tdi;
  logic cdr1, sdr1, udr1;
  logic cir1, sir1, uir1;
  logic tdo;
  logic tdo_en;

  modport master (output tdi, cdr1, sdr1, udr1, cir1, sir1, uir1,
                  input  tdo, tdo_en);
  modport slave  (input  tdi, cdr1, sdr1, udr1, cir1, sir1, uir1,
                  output tdo, tdo_en);
endinterface

// File: rtl/jtag_ir_dr_regs.sv
// JTAG instruction register plus BYPASS / IDCODE / USER data registers,
// sitting directly behind the TAP FSM.
// Optional feature macro: JTAG_USER_DR_EN builds the USER data register.
// Without it, OP_USER decodes as BYPASS and the user outputs are tied to 0.
module jtag_ir_dr_regs #(
  parameter int              IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h1234_5093,
  parameter int              USER_W     = 8,
  parameter logic [IR_W-1:0] OP_IDCODE  = 4'b0001,
  parameter logic [IR_W-1:0] OP_USER    = 4'b0010
) (
  input  logic              tck,
  input  logic              trst,
  jtag_ir_dr_regs_if.slave  tap,
  output logic [IR_W-1:0]   ir_out,
  input  logic [USER_W-1:0] user_dr_in,
  output logic [USER_W-1:0] user_dr_out,
  output logic              user_update
);

  // IR capture pattern: LSBs 01, rest zero
  localparam logic [IR_W-1:0] IR_CAP = IR_W'(1);

  logic [IR_W-1:0] ir_sr, ir;
  logic            bypass_sr;
  logic [31:0]     id_sr;
  logic            sel_id, sel_user, sel_bypass;
  logic            ir_act, dr_cap, dr_sh, dr_upd;
  logic            user_lsb;

  // Any IR strobe locks out the DR path; DR strobes keep their own priority
  assign ir_act = tap.cir1 | tap.sir1 | tap.uir1;
  assign dr_cap = tap.cdr1 & ~ir_act;
  assign dr_sh  = tap.sdr1 & ~ir_act & ~tap.cdr1;
  assign dr_upd = tap.udr1 & ~ir_act & ~tap.cdr1 & ~tap.sdr1;

  assign sel_id     = (ir == OP_IDCODE);
  assign sel_bypass = ~sel_id & ~sel_user;

  // Instruction shift register and active instruction
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_sr <= '0;
      ir    <= OP_IDCODE;
    end else if (tap.cir1) begin
      ir_sr <= IR_CAP;
    end else if (tap.sir1) begin
      ir_sr <= {tap.tdi, ir_sr[IR_W-1:1]};
    end else if (tap.uir1) begin
      ir    <= ir_sr;
    end
  end

  // BYPASS: one bit, captured as 0
  always_ff @(posedge tck) begin
    if (trst)                    bypass_sr <= 1'b0;
    else if (dr_cap & sel_bypass) bypass_sr <= 1'b0;
    else if (dr_sh & sel_bypass)  bypass_sr <= tap.tdi;
  end

  // IDCODE: capture constant, shift right with tdi at the MSB
  always_ff @(posedge tck) begin
    if (trst)                 id_sr <= '0;
    else if (dr_cap & sel_id) id_sr <= IDCODE_VAL;
    else if (dr_sh & sel_id)  id_sr <= {tap.tdi, id_sr[31:1]};
  end

`ifdef JTAG_USER_DR_EN
  logic [USER_W-1:0] user_sr;

  assign sel_user = (ir == OP_USER) & (ir != OP_IDCODE);
  assign user_lsb = user_sr[0];

  // USER: capture core value, shift, then publish with a one-cycle strobe
  always_ff @(posedge tck) begin
    if (trst) begin
      user_sr     <= '0;
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (dr_cap & sel_user)      user_sr <= user_dr_in;
      else if (dr_sh & sel_user)  user_sr <= {tap.tdi, user_sr[USER_W-1:1]};
      else if (dr_upd & sel_user) begin
        user_dr_out <= user_sr;
        user_update <= 1'b1;
      end
    end
  end
`else
  // USER not built: outputs tied off, inputs only feed a sink net
  logic unused_user;
  assign unused_user = ^{user_dr_in, OP_USER, dr_upd};
  assign sel_user    = 1'b0;
  assign user_lsb    = 1'b0;
  assign user_dr_out = '0;
  assign user_update = 1'b0;
`endif

  // Serial return: IR shift wins, else LSB of the selected DR while shifting
  always_comb begin
    tap.tdo = 1'b0;
    if (tap.sir1)      tap.tdo = ir_sr[0];
    else if (tap.sdr1) tap.tdo = sel_id ? id_sr[0] : (sel_user ? user_lsb : bypass_sr);
  end

  assign tap.tdo_en = tap.sir1 | tap.sdr1;
  assign ir_out     = ir;

endmodule

// File: tb/tb_jtag_ir_dr_regs.sv
// Directed bench for jtag_ir_dr_regs. Inputs change 1 time unit after the
// rising edge; tdo/tdo_en are sampled on the falling edge of the same cycle.
// Expectations follow whichever build (JTAG_USER_DR_EN or not) is compiled.
module tb_jtag_ir_dr_regs;
  localparam logic [31:0] IDV = 32'h1234_5093;
  // strobe code order {cdr1, sdr1, udr1, cir1, sir1, uir1}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_CDR  = 6'b100000;
  localparam logic [5:0] S_SDR  = 6'b010000;
  localparam logic [5:0] S_UDR  = 6'b001000;
  localparam logic [5:0] S_CIR  = 6'b000100;
  localparam logic [5:0] S_SIR  = 6'b000010;
  localparam logic [5:0] S_UIR  = 6'b000001;

  logic       tck = 1'b0;
  logic       trst;
  logic [3:0] ir_out;
  logic [7:0] user_dr_in, user_dr_out;
  logic       user_update;

  int n_chk = 0;
  int n_err = 0;

  jtag_ir_dr_regs_if tap();

  jtag_ir_dr_regs dut (
    .tck(tck), .trst(trst), .tap(tap), .ir_out(ir_out),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One TAP cycle: apply strobes/tdi, sample serial outputs mid-cycle, clock it
  task automatic step(input logic [5:0] st, input logic t, output logic o_tdo, output logic o_en);
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = st;
    tap.tdi = t;
    @(negedge tck);
    o_tdo = tap.tdo;
    o_en  = tap.tdo_en;
    @(posedge tck);
    #1;
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = S_NONE;
    tap.tdi = 1'b0;
  endtask

  // n Shift-DR cycles, bit k of din in on cycle k, bit k of dout is tdo on cycle k
  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout, output int en_cnt);
    logic o, e;
    dout = '0;
    en_cnt = 0;
    for (int k = 0; k < n; k++) begin
      step(S_SDR, din[k], o, e);
      dout[k] = o;
      if (e) en_cnt++;
    end
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] out_bits);
    logic o, e;
    step(S_CIR, 1'b0, o, e);
    for (int k = 0; k < 4; k++) begin
      step(S_SIR, v[k], o, e);
      out_bits[k] = o;
    end
    step(S_UIR, 1'b0, o, e);
  endtask

  initial begin
    logic        o, e;
    logic [63:0] dout;
    logic [3:0]  irb;
    int          en_cnt;
    logic [7:0]  exp_user_tdo, exp_user_out;
    logic        exp_upd;

`ifdef JTAG_USER_DR_EN
    exp_user_tdo = 8'hA5;   // captured user_dr_in comes out
    exp_user_out = 8'h3C;
    exp_upd      = 1'b1;
`else
    exp_user_tdo = 8'h78;   // bypass: 0 then tdi (3C) delayed one cycle
    exp_user_out = 8'h00;
    exp_upd      = 1'b0;
`endif

    trst = 1'b1;
    user_dr_in = 8'h00;
    tap.tdi = 1'b0;
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = S_NONE;

    // Reset state, strobes ignored while in reset
    step(S_CIR, 1'b1, o, e);
    step(S_NONE, 1'b0, o, e);
    chk("rst_tdo", o, 0);
    chk("rst_tdo_en", e, 0);
    chk("rst_ir", ir_out, 4'b0001);
    chk("rst_user_out", user_dr_out, 0);
    chk("rst_user_upd", user_update, 0);
    trst = 1'b0;

    // IDCODE capture and 32-bit shift out
    step(S_CDR, 1'b0, o, e);
    chk("cap_tdo_en", e, 0);
    shift_dr(32, 64'h0, dout, en_cnt);
    chk("idcode", dout[31:0], IDV);
    chk("idcode_en_cnt", en_cnt, 32);
    step(S_NONE, 1'b0, o, e);
    chk("idle_tdo_en", e, 0);

    // Overlong shift: the first tdi bits reappear after 32 cycles
    step(S_CDR, 1'b0, o, e);
    shift_dr(40, 64'h00_0000_00C3_0000_0000 | 64'h96, dout, en_cnt);
    chk("id_long_head", dout[31:0], IDV);
    chk("id_long_tail", dout[39:32], 8'h96);

    // IR capture pattern and all-ones -> BYPASS
    load_ir(4'hF, irb);
    chk("ir_cap_tdo", irb, 4'b0001);
    chk("ir_F", ir_out, 4'hF);
    step(S_CDR, 1'b0, o, e);
    shift_dr(4, 64'b1101, dout, en_cnt);
    chk("bypass_F", dout[3:0], 4'b1010);

    // USER register round trip (BYPASS when not built)
    user_dr_in = 8'hA5;
    load_ir(4'b0010, irb);
    chk("ir_user", ir_out, 4'b0010);
    step(S_CDR, 1'b0, o, e);
    shift_dr(8, 64'h3C, dout, en_cnt);
    chk("user_tdo", dout[7:0], exp_user_tdo);
    step(S_UDR, 1'b0, o, e);
    chk("user_out", user_dr_out, exp_user_out);
    chk("user_upd_on", user_update, exp_upd);
    step(S_NONE, 1'b0, o, e);
    chk("user_upd_off", user_update, 0);
    chk("user_out_hold", user_dr_out, exp_user_out);

    // IR strobe alongside a DR update: DR side ignored
    step(S_CIR | S_UDR, 1'b0, o, e);
    chk("collide_upd", user_update, 0);

    // Undefined opcode -> BYPASS
    load_ir(4'h7, irb);
    chk("ir_7", ir_out, 4'h7);
    step(S_CDR, 1'b0, o, e);
    shift_dr(4, 64'b1011, dout, en_cnt);
    chk("bypass_7", dout[3:0], 4'b0110);

    // Reset in the middle of a USER shift discards everything
    user_dr_in = 8'h5A;
    load_ir(4'b0010, irb);
    step(S_CDR, 1'b0, o, e);
    shift_dr(3, 64'b101, dout, en_cnt);
    trst = 1'b1;
    step(S_SDR, 1'b1, o, e);
    trst = 1'b0;
    chk("mid_rst_ir", ir_out, 4'b0001);
    chk("mid_rst_out", user_dr_out, 0);
    step(S_UDR, 1'b0, o, e);
    chk("mid_rst_upd", user_update, 0);
    chk("mid_rst_out2", user_dr_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_ir_dr_regs.md
# jtag_ir_dr_regs

- Register stage directly downstream of the JTAG TAP controller FSM.
- Consumes the TAP's one-state-wide capture/shift/update strobes for DR (`cdr1`, `sdr1`, `udr1`) and IR (`cir1`, `sir1`, `uir1`) plus serial `tdi`.
- Contains the instruction register and three data registers: BYPASS, IDCODE and an optional USER register.
- Drives `tdo`/`tdo_en` back to the pin, and `user_dr_out` to core logic.

## Interface
Parameters:
- `IR_W`, 4: instruction register width, ≥2.
- `IDCODE_VAL`, 32'h1234_5093: IDCODE capture value; bit 0 must be 1.
- `USER_W`, 8: USER data register width, ≥1.
- `OP_IDCODE`, 4'b0001: IDCODE opcode, also the reset instruction.
- `OP_USER`, 4'b0010: USER opcode.
- All-ones opcode and every undefined opcode select BYPASS.

Ports:
- `tck` input 1: the single clock; all state updates on the rising edge.
- `trst` input 1: reset, synchronous, active-high.
- `tdi` input 1: serial data in.
- `cdr1`, `sdr1`, `udr1` input 1 each: TAP is in Capture-DR / Shift-DR / Update-DR.
- `cir1`, `sir1`, `uir1` input 1 each: TAP is in Capture-IR / Shift-IR / Update-IR.
- `tdo` output 1: serial data out.
- `tdo_en` output 1: high while shifting.
- `ir_out` output IR_W: active instruction.
- `user_dr_in` input USER_W: parallel value captured into USER.
- `user_dr_out` output USER_W: updated USER value.
- `user_update` output 1: one-cycle pulse when `user_dr_out` is loaded.

## Operation
- State: `ir_sr`[IR_W], `ir`[IR_W], `bypass_sr`[1], `id_sr`[32], `user_sr`[USER_W], `user_dr_out`, `user_update`.
- Decode from `ir`: IDCODE, USER, or BYPASS (all other opcodes).
- On a rising edge with `trst`=1:
  - `ir` ← OP_IDCODE.
  - All shift registers ← 0.
  - `user_dr_out` ← 0 and `user_update` ← 0.
  - Strobes are ignored.
- IR path, priority `cir1` > `sir1` > `uir1`:
  - `cir1`: `ir_sr` ← {0…0, 2'b01}, so the LSBs are 01.
  - `sir1`: `ir_sr` ← {`tdi`, `ir_sr`[IR_W-1:1]}.
  - `uir1`: `ir` ← `ir_sr`.
- DR path, priority `cdr1` > `sdr1` > `udr1`; only the selected DR is affected:
  - `cdr1`: BYPASS ← 0; IDCODE ← IDCODE_VAL; USER ← `user_dr_in`.
  - `sdr1`: the selected register shifts right, with `tdi` entering at the MSB.
  - `udr1`: if USER is selected, `user_dr_out` ← `user_sr` and `user_update` ← 1. BYPASS and IDCODE have no update action.
- `user_update` returns to 0 on the next edge; it is never high for two consecutive cycles.
- Simultaneous IR and DR strobes (illegal from a correct TAP): any IR strobe wins and all DR strobes are ignored that cycle.
- `tdo`, combinational from registers and strobes:
  - `sir1` → `ir_sr`[0].
  - Otherwise `sdr1` → LSB of the selected DR.
  - Otherwise 0.
- `tdo_en` = `sir1` | `sdr1`.
- `ir_out` = `ir`.

## Timing
- Capture → first `tdo` bit: the captured LSB is on `tdo` during the first shift cycle, before that edge.
- N-bit register: N shift cycles output bits 0…N-1. The bit shifted in on shift cycle k appears on `tdo` on shift cycle k+N.
- BYPASS: `tdo` equals `tdi` delayed by one shift cycle; the first bit is 0.
- `ir` changes on the `uir1` edge. The new DR selection applies from the next cycle.
- `user_dr_out` and `user_update` change on the same edge (`udr1` edge). Core logic samples `user_dr_out` while `user_update`=1.
- Shifting longer than N: excess bits fall off the LSB. Only the last N `tdi` bits are retained.
- Reset mid-shift or mid-update: reset takes effect on that edge. A pending update is discarded.
- Outputs after reset:
  - `ir_out`=OP_IDCODE.
  - `tdo`=0 and `tdo_en`=0 (strobes low).
  - `user_dr_out`=0 and `user_update`=0.

## Configuration
- `JTAG_USER_DR_EN` defined: USER register is implemented as described.
- `JTAG_USER_DR_EN` undefined:
  - OP_USER decodes as BYPASS and `user_sr` is not built.
  - `user_dr_out` is held at 0 and `user_update` at 0.
  - `user_dr_in` is ignored.
  - Ports are unchanged.

## Test plan
- Reset then `cdr1`, then 32×`sdr1` with `tdi`=0 → `tdo` emits 32'h1234_5093 LSB-first. `tdo_en`=1 only during the shifts.
- `cir1`, then 4×`sir1` with `tdi`=1,1,1,1, then `uir1`:
  - `tdo` = 1,0,0,0.
  - `ir_out`=4'hF.
  - A subsequent DR shift of `tdi`=1,0,1,1 gives `tdo`=0,1,0,1.
- Load IR=4'b0010 and set `user_dr_in`=8'hA5. Then `cdr1`, 8×`sdr1` shifting 8'h3C LSB-first, then `udr1`:
  - `tdo` = 8'hA5 LSB-first.
  - `user_dr_out`=8'h3C with `user_update` high for exactly one cycle.
- Load IR=4'h7 (undefined) → DR path behaves as 1-bit BYPASS.
- Load IR=USER, assert `trst` mid-shift on bit 3, then `udr1`:
  - `ir_out`=4'b0001.
  - `user_dr_out` stays 0 and `user_update` stays 0.
- Build without `JTAG_USER_DR_EN`, then repeat the USER scenario:
  - BYPASS behaviour.
  - `user_dr_out`=0 and `user_update` never asserts.
